// File: rtl/drive_sequencer.sv
// Drive sequencer: turns the three filtered line sensors into a drive state and ramps
// each wheel's duty and direction toward that state's targets once per control tick.
module drive_sequencer #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned FWD_DUTY     = 200,
  parameter int unsigned TURN_DUTY    = 120,
  parameter int unsigned SPIN_DUTY    = 100,
  parameter int unsigned RAMP_STEP    = 8,
  parameter int unsigned LOST_TICKS   = 200,
  parameter int unsigned SEARCH_TICKS = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sens_l,
  input  logic       sens_m,
  input  logic       sens_r,
  output logic [7:0] duty_l,
  output logic [7:0] duty_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic [2:0] state,
  output logic       lost
);

  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LOST_W   = $clog2(LOST_TICKS + 1);
  localparam int unsigned SEARCH_W = $clog2(SEARCH_TICKS + 1);

  localparam logic [7:0] FWD_D  = 8'(FWD_DUTY);
  localparam logic [7:0] TURN_D = 8'(TURN_DUTY);
  localparam logic [7:0] SPIN_D = 8'(SPIN_DUTY);
  localparam logic [7:0] STEP   = 8'(RAMP_STEP);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FOLLOW = 3'd1,
    ST_TURN_L = 3'd2,
    ST_TURN_R = 3'd3,
    ST_SEARCH = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [LOST_W-1:0]   lost_cnt_q, lost_cnt_d;
  logic [SEARCH_W-1:0] search_cnt_q, search_cnt_d;
  state_e              state_q, state_d;
  logic                last_left_q, last_left_d;
  logic                lost_q, lost_d;
  logic [7:0]          duty_l_q, duty_l_d, duty_r_q, duty_r_d;
  logic                dir_l_q, dir_l_d, dir_r_q, dir_r_d;

  logic                tick_c;
  logic                any_c;
  state_e              dec_c;
  logic                tdir_l_c, tdir_r_c;
  logic [7:0]          tgt_l_c, tgt_r_c;

  // One wheel's ramp step: {dir, duty}. Direction only flips once duty has reached zero.
  function automatic logic [8:0] ramp(input logic dir, input logic [7:0] duty,
                                      input logic tdir, input logic [7:0] tgt);
    logic       n_dir;
    logic [7:0] n_duty;
    n_dir  = dir;
    n_duty = duty;
    if (dir != tdir) begin
      if (duty == 8'd0) n_dir = tdir;
      else if (duty > STEP) n_duty = duty - STEP;
      else n_duty = 8'd0;
    end else if (tgt > duty) begin
      n_duty = ((tgt - duty) > STEP) ? duty + STEP : tgt;
    end else if (tgt < duty) begin
      n_duty = ((duty - tgt) > STEP) ? duty - STEP : tgt;
    end
    return {n_dir, n_duty};
  endfunction

  assign tick_c = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign any_c  = sens_l | sens_m | sens_r;

  always_comb begin
    dec_c = ST_FOLLOW;
    if (sens_l && !sens_r) dec_c = ST_TURN_L;
    else if (!sens_l && sens_r) dec_c = ST_TURN_R;
  end

  // Next drive state and the lost / search counters.
  always_comb begin
    state_d      = state_q;
    lost_cnt_d   = lost_cnt_q;
    search_cnt_d = search_cnt_q;
    last_left_d  = last_left_q;
    tick_cnt_d   = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
    if (tick_c) begin
      if (!enable) begin
        state_d      = ST_IDLE;
        lost_cnt_d   = '0;
        search_cnt_d = '0;
      end else begin
        case (state_q)
          ST_STOP: ;
          ST_IDLE: begin
            lost_cnt_d   = '0;
            search_cnt_d = '0;
            state_d      = any_c ? dec_c : ST_SEARCH;
          end
          ST_SEARCH: begin
            if (any_c) begin
              state_d      = dec_c;
              search_cnt_d = '0;
            end else begin
              search_cnt_d = search_cnt_q + SEARCH_W'(1);
              if (search_cnt_q == SEARCH_W'(SEARCH_TICKS - 1)) state_d = ST_STOP;
            end
          end
          default: begin
            if (any_c) begin
              state_d    = dec_c;
              lost_cnt_d = '0;
            end else if (lost_cnt_q == LOST_W'(LOST_TICKS - 1)) begin
              state_d      = ST_SEARCH;
              lost_cnt_d   = '0;
              search_cnt_d = '0;
            end else begin
              lost_cnt_d = lost_cnt_q + LOST_W'(1);
            end
          end
        endcase
      end
      if (state_d == ST_TURN_L) last_left_d = 1'b1;
      else if (state_d == ST_TURN_R) last_left_d = 1'b0;
    end
  end

  // Wheel targets for the state being entered; zero targets keep the current direction.
  always_comb begin
    tdir_l_c = dir_l_q;
    tdir_r_c = dir_r_q;
    tgt_l_c  = 8'd0;
    tgt_r_c  = 8'd0;
    case (state_d)
      ST_FOLLOW: begin
        tdir_l_c = 1'b1; tdir_r_c = 1'b1; tgt_l_c = FWD_D;  tgt_r_c = FWD_D;
      end
      ST_TURN_L: begin
        tdir_l_c = 1'b1; tdir_r_c = 1'b1; tgt_l_c = TURN_D; tgt_r_c = FWD_D;
      end
      ST_TURN_R: begin
        tdir_l_c = 1'b1; tdir_r_c = 1'b1; tgt_l_c = FWD_D;  tgt_r_c = TURN_D;
      end
      ST_SEARCH: begin
        tdir_l_c = !last_left_d;
        tdir_r_c = last_left_d;
        tgt_l_c  = SPIN_D;
        tgt_r_c  = SPIN_D;
      end
      default: ;
    endcase
  end

  always_comb begin
    {dir_l_d, duty_l_d} = {dir_l_q, duty_l_q};
    {dir_r_d, duty_r_d} = {dir_r_q, duty_r_q};
    if (tick_c) begin
      {dir_l_d, duty_l_d} = ramp(dir_l_q, duty_l_q, tdir_l_c, tgt_l_c);
      {dir_r_d, duty_r_d} = ramp(dir_r_q, duty_r_q, tdir_r_c, tgt_r_c);
    end
    lost_d = (state_d == ST_SEARCH) || (state_d == ST_STOP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      lost_cnt_q   <= '0;
      search_cnt_q <= '0;
      state_q      <= ST_IDLE;
      last_left_q  <= 1'b1;
      lost_q       <= 1'b0;
      duty_l_q     <= 8'd0;
      duty_r_q     <= 8'd0;
      dir_l_q      <= 1'b1;
      dir_r_q      <= 1'b1;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      lost_cnt_q   <= lost_cnt_d;
      search_cnt_q <= search_cnt_d;
      state_q      <= state_d;
      last_left_q  <= last_left_d;
      lost_q       <= lost_d;
      duty_l_q     <= duty_l_d;
      duty_r_q     <= duty_r_d;
      dir_l_q      <= dir_l_d;
      dir_r_q      <= dir_r_d;
    end
  end

  assign duty_l = duty_l_q;
  assign duty_r = duty_r_q;
  assign dir_l  = dir_l_q;
  assign dir_r  = dir_r_q;
  assign state  = state_q;
  assign lost   = lost_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with a 4-clock control tick and short lost/search limits.
module tb_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       sens_l, sens_m, sens_r;
  logic [7:0] duty_l, duty_r;
  logic       dir_l, dir_r;
  logic [2:0] state;
  logic       lost;

  int n_run  = 0;
  int n_fail = 0;

  logic [21:0] obs;
  logic [21:0] exp_v;
  assign obs = {state, lost, dir_l, dir_r, duty_l, duty_r};

  drive_sequencer #(
    .TICK_DIV(4), .RAMP_STEP(8), .LOST_TICKS(3), .SEARCH_TICKS(5)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .sens_l(sens_l), .sens_m(sens_m), .sens_r(sens_r),
    .duty_l(duty_l), .duty_r(duty_r), .dir_l(dir_l), .dir_r(dir_r),
    .state(state), .lost(lost)
  );

  always #5 clk = ~clk;

  // Expected output vector: state, lost, dir_l, dir_r, duty_l, duty_r.
  function automatic logic [21:0] ev(input int st, input int lo, input int dl, input int dr,
                                      input int yl, input int yr);
    return {3'(st), 1'(lo), 1'(dl), 1'(dr), 8'(yl), 8'(yr)};
  endfunction

  function automatic int clip(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Direction may only change across an edge where the matching duty was zero.
  logic       p_dir_l, p_dir_r;
  logic [7:0] p_duty_l, p_duty_r;
  logic       mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (dir_l !== p_dir_l) begin
        n_run++;
        if (p_duty_l !== 8'd0) begin
          n_fail++;
          $display("FAIL dir_l_flip_under_load: dir_l changed with duty_l=%0d, required 0", p_duty_l);
        end
      end
      if (dir_r !== p_dir_r) begin
        n_run++;
        if (p_duty_r !== 8'd0) begin
          n_fail++;
          $display("FAIL dir_r_flip_under_load: dir_r changed with duty_r=%0d, required 0", p_duty_r);
        end
      end
    end
    p_dir_l  = dir_l;
    p_dir_r  = dir_r;
    p_duty_l = duty_l;
    p_duty_r = duty_r;
  end

  task automatic tick();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int k);
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h required %h", name, k, obs, exp_v);
    end
    n_run++;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; {sens_l, sens_m, sens_r} = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    exp_v = ev(0, 0, 1, 1, 0, 0); chk("reset", 0);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_follow();
    enable = 1'b1; sens_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_v = ev(0, 0, 1, 1, 0, 0); chk("pre_tick_idle", 3);
    @(posedge clk);
    #1;
    exp_v = ev(1, 0, 1, 1, 8, 8); chk("follow_first_tick", 1);
    for (int k = 2; k <= 26; k++) begin
      tick();
      exp_v = ev(1, 0, 1, 1, clip(8 * k, 0, 200), clip(8 * k, 0, 200));
      chk("follow_ramp", k);
    end
  endtask

  task automatic test_turn_l();
    sens_l = 1'b1; sens_m = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      exp_v = ev(2, 0, 1, 1, clip(200 - 8 * k, 120, 200), 200);
      chk("turn_l_ramp", k);
    end
  endtask

  task automatic test_lost_search();
    sens_l = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      exp_v = ev(2, 0, 1, 1, 120, 200); chk("lost_hold", k);
    end
    tick();
    exp_v = ev(4, 1, 1, 1, 112, 192); chk("search_entry", 3);
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_v = ev(4, 1, 1, 1, 112 - 8 * k, 192 - 8 * k); chk("search_spin", k);
    end
    tick();
    exp_v = ev(5, 1, 1, 1, 72, 152); chk("stop_entry", 5);
  endtask

  task automatic test_stop_hold();
    sens_m = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_v = ev(5, 1, 1, 1, clip(72 - 8 * k, 0, 255), clip(152 - 8 * k, 0, 255));
      chk("stop_ramp_down", k);
    end
  endtask

  task automatic test_enable_low();
    enable = 1'b0;
    tick(); exp_v = ev(0, 0, 1, 1, 0, 0); chk("stop_to_idle", 0);
    enable = 1'b1;
    tick(); exp_v = ev(1, 0, 1, 1, 8, 8);   chk("idle_to_follow", 1);
    tick(); exp_v = ev(1, 0, 1, 1, 16, 16); chk("idle_to_follow", 2);
    enable = 1'b0;
    tick(); exp_v = ev(0, 0, 1, 1, 8, 8);   chk("disable_ramps", 1);
    tick(); exp_v = ev(0, 0, 1, 1, 0, 0);   chk("disable_ramps", 2);
  endtask

  task automatic test_lost_clear();
    enable = 1'b1; sens_m = 1'b1;
    tick(); exp_v = ev(1, 0, 1, 1, 8, 8); chk("clear_follow", 1);
    sens_m = 1'b0;
    tick(); exp_v = ev(1, 0, 1, 1, 16, 16); chk("clear_lost", 1);
    tick(); exp_v = ev(1, 0, 1, 1, 24, 24); chk("clear_lost", 2);
    sens_m = 1'b1;
    tick(); exp_v = ev(1, 0, 1, 1, 32, 32); chk("clear_seen", 3);
    sens_m = 1'b0;
    tick(); exp_v = ev(1, 0, 1, 1, 40, 40); chk("clear_relost", 4);
    tick(); exp_v = ev(1, 0, 1, 1, 48, 48); chk("clear_relost", 5);
    sens_l = 1'b1; sens_r = 1'b1;
    tick(); exp_v = ev(1, 0, 1, 1, 56, 56); chk("both_sides_follow", 6);
    sens_l = 1'b0; sens_r = 1'b0; enable = 1'b0;
    repeat (7) tick();
    exp_v = ev(0, 0, 1, 1, 0, 0); chk("clear_rest", 7);
  endtask

  task automatic test_search_reverse();
    enable = 1'b1; sens_m = 1'b1;
    tick(); exp_v = ev(1, 0, 1, 1, 8, 8); chk("rev_follow", 0);
    sens_m = 1'b0;
    tick(); exp_v = ev(1, 0, 1, 1, 16, 16); chk("rev_lost", 1);
    tick(); exp_v = ev(1, 0, 1, 1, 24, 24); chk("rev_lost", 2);
    tick(); exp_v = ev(4, 1, 1, 1, 16, 32); chk("rev_search", 0);
    tick(); exp_v = ev(4, 1, 1, 1, 8, 40);  chk("rev_search", 1);
    tick(); exp_v = ev(4, 1, 1, 1, 0, 48);  chk("rev_search", 2);
    tick(); exp_v = ev(4, 1, 0, 1, 0, 56);  chk("rev_dir_flip", 3);
    tick(); exp_v = ev(4, 1, 0, 1, 8, 64);  chk("rev_spin_up", 4);
    sens_r = 1'b1;
    tick(); exp_v = ev(3, 0, 0, 1, 0, 72);  chk("recover_turn_r", 0);
    tick(); exp_v = ev(3, 0, 1, 1, 0, 80);  chk("recover_turn_r", 1);
    tick(); exp_v = ev(3, 0, 1, 1, 8, 88);  chk("recover_turn_r", 2);
  endtask

  task automatic test_idle_search_right();
    sens_r = 1'b0; enable = 1'b0;
    tick(); exp_v = ev(0, 0, 1, 1, 0, 80); chk("idle_rest", 0);
    repeat (10) tick();
    exp_v = ev(0, 0, 1, 1, 0, 0); chk("idle_rest", 10);
    enable = 1'b1;
    tick(); exp_v = ev(4, 1, 1, 0, 8, 0);  chk("idle_to_search_right", 1);
    tick(); exp_v = ev(4, 1, 1, 0, 16, 8); chk("idle_to_search_right", 2);
  endtask

  task automatic test_reset_mid();
    sens_m = 1'b1;
    repeat (30) tick();
    exp_v = ev(1, 0, 1, 1, 200, 200); chk("full_speed", 30);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_v = ev(0, 0, 1, 1, 0, 0); chk("reset_mid_motion", 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_v = ev(0, 0, 1, 1, 0, 0); chk("tick_restart_idle", 3);
    @(posedge clk);
    #1;
    exp_v = ev(1, 0, 1, 1, 8, 8); chk("tick_restart_follow", 4);
  endtask

  initial begin
    test_reset();
    test_follow();
    test_turn_l();
    test_lost_search();
    test_stop_hold();
    test_enable_low();
    test_lost_clear();
    test_search_reverse();
    test_idle_search_right();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
